// File: rtl/writeback_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// writeback_stage : result select, register file, busy scoreboard, NZP, retire count
// Rev 1.0
// ---------------------------------------------------------------------------
module writeback_stage #(
  parameter int REG_WIDTH    = 16,
  parameter int NUM_REGS     = 16,
  parameter int CNT_WIDTH    = 32,
  parameter int OPCODE_WIDTH = 8
) (
  input  logic                    I_CLOCK,
  input  logic                    I_RESET,
  input  logic                    I_LOCK,
  input  logic [REG_WIDTH-1:0]    I_ALUOut,
  input  logic [REG_WIDTH-1:0]    I_MemOut,
  input  logic [OPCODE_WIDTH-1:0] I_Opcode,
  input  logic [3:0]              I_DestRegIdx,
  input  logic                    I_FetchStall,
  input  logic                    I_DepStall,
  input  logic                    I_IssueValid,
  input  logic [3:0]              I_IssueRegIdx,
  input  logic [3:0]              I_RdIdx1,
  input  logic [3:0]              I_RdIdx2,
  output logic [REG_WIDTH-1:0]    O_RdData1,
  output logic [REG_WIDTH-1:0]    O_RdData2,
  output logic [NUM_REGS-1:0]     O_Busy,
  output logic [2:0]              O_CC,
  output logic [CNT_WIDTH-1:0]    O_RetireCount,
  output logic                    O_WrEn,
  output logic [3:0]              O_WrIdx,
  output logic [REG_WIDTH-1:0]    O_WrData
);

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = OPCODE_WIDTH'(8'h00);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDW   = OPCODE_WIDTH'(8'h10);
  localparam logic [OPCODE_WIDTH-1:0] OP_STW   = OPCODE_WIDTH'(8'h11);
  localparam logic [OPCODE_WIDTH-1:0] OP_BRN   = OPCODE_WIDTH'(8'h20);
  localparam logic [OPCODE_WIDTH-1:0] OP_BRNZP = OPCODE_WIDTH'(8'h26);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP   = OPCODE_WIDTH'(8'h30);
  localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = OPCODE_WIDTH'(8'h3F);

  logic [REG_WIDTH-1:0] regs [NUM_REGS];
  logic                 retire;
  logic                 writes_reg;
  logic                 wr;
  logic [REG_WIDTH-1:0] wb_value;
  logic [2:0]           wb_cc;

  always_comb begin
    writes_reg = 1'b1;
    if (I_Opcode == OP_STW || I_Opcode == OP_JMP || I_Opcode == OP_NOP ||
        (I_Opcode >= OP_BRN && I_Opcode <= OP_BRNZP))
      writes_reg = 1'b0;
  end

  assign retire   = I_LOCK & ~I_FetchStall & ~I_DepStall;
  assign wr       = retire & writes_reg;
  assign wb_value = (I_Opcode == OP_LDW) ? I_MemOut : I_ALUOut;

  always_comb begin
    wb_cc = 3'b001;
    if (wb_value[REG_WIDTH-1])
      wb_cc = 3'b100;
    else if (wb_value == '0)
      wb_cc = 3'b010;
  end

  // Same-cycle bypass lets decode see a result in the cycle it retires.
  assign O_RdData1 = (wr && I_DestRegIdx == I_RdIdx1) ? wb_value : regs[I_RdIdx1];
  assign O_RdData2 = (wr && I_DestRegIdx == I_RdIdx2) ? wb_value : regs[I_RdIdx2];

  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
      O_CC          <= 3'b010;
      O_RetireCount <= '0;
      O_WrEn        <= 1'b0;
      O_WrIdx       <= '0;
      O_WrData      <= '0;
    end else begin
      O_WrEn <= wr;
      if (retire)
        O_RetireCount <= O_RetireCount + 1'b1;
      if (wr) begin
        regs[I_DestRegIdx] <= wb_value;
        O_CC               <= wb_cc;
        O_WrIdx            <= I_DestRegIdx;
        O_WrData           <= wb_value;
      end
    end
  end

  // The issue set is ordered after the retire clear so a newer producer wins.
  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      O_Busy <= '0;
    end else begin
      if (wr)
        O_Busy[I_DestRegIdx] <= 1'b0;
      if (I_LOCK && I_IssueValid)
        O_Busy[I_IssueRegIdx] <= 1'b1;
    end
  end

  logic unused_ok;
  assign unused_ok = ^OP_ADD;

endmodule
`default_nettype wire

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage. Sits directly downstream of the memory stage and consumes its registered outputs: lock, ALU result, memory-read result, opcode, destination index and stall flags.
- Selects the write-back value and owns the architectural register file; decode reads operands from it.
- Maintains a busy-bit scoreboard that decode uses for dependency stalls, the NZP condition codes used by branches, and a retired-instruction counter.

Parameters:
- REG_WIDTH, 16, data width of the register file and datapath.
- NUM_REGS, 16, number of architectural registers; indexed by 4 bits.
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- I_CLOCK  input  1  pipeline clock; all state updates on its falling edge.
- I_RESET  input  1  synchronous, active-high reset.
- I_LOCK  input  1  pipeline-running flag from the memory stage.
- I_ALUOut  input  REG_WIDTH  ALU result from the memory stage.
- I_MemOut  input  REG_WIDTH  load data from the memory stage.
- I_Opcode  input  OPCODE_WIDTH  opcode of the instruction in writeback.
- I_DestRegIdx  input  4  destination register index.
- I_FetchStall  input  1  bubble flag from upstream.
- I_DepStall  input  1  bubble flag from upstream.
- I_IssueValid  input  1  decode issued an instruction that will write a register.
- I_IssueRegIdx  input  4  destination index of that issued instruction.
- I_RdIdx1, I_RdIdx2  input  4 each  decode read addresses.
- O_RdData1, O_RdData2  output  REG_WIDTH each  read data; combinational, with bypass.
- O_Busy  output  NUM_REGS  scoreboard bits, one per register.
- O_CC  output  3  condition codes {N,Z,P}.
- O_RetireCount  output  CNT_WIDTH  count of retired instructions.
- O_WrEn  output  1  registered pulse: a register write occurred on the last edge.
- O_WrIdx  output  4  index written on the last edge.
- O_WrData  output  REG_WIDTH  value written on the last edge.

Behaviour:
- Reset (checked on the falling edge, overrides all other activity):
  - all registers = 0, O_Busy = 0, O_CC = 3'b010.
  - O_RetireCount = 0, O_WrEn = 0, O_WrIdx = 0, O_WrData = 0.
  - An in-flight retire or issue on the reset edge is discarded.
- Definitions:
  - retire = I_LOCK & ~I_FetchStall & ~I_DepStall.
  - wr = retire & the opcode writes a register. Non-writing opcodes are OP_STW, OP_BRN..OP_BRNZP, OP_JMP and OP_NOP; all others write. JSR/JSRR write whatever I_DestRegIdx upstream supplies.
  - Write value = I_MemOut for OP_LDW, else I_ALUOut.
- I_LOCK == 0 (not reset): no register write, no scoreboard change, counter held, CC held. O_WrEn is cleared to 0.
- On each falling edge with retire:
  - O_RetireCount increments by 1, wrapping from all-ones to 0. Writing and non-writing opcodes both count.
  - If wr:
    - register[I_DestRegIdx] <= value.
    - O_Busy[I_DestRegIdx] cleared.
    - O_CC <= N = value[MSB]; Z = (value == 0); P otherwise. Exactly one bit is set.
    - O_WrEn = 1, O_WrIdx / O_WrData = index / value.
  - Otherwise O_WrEn = 0, and O_CC and registers are unchanged.
- Issue: on a falling edge with I_LOCK & I_IssueValid, O_Busy[I_IssueRegIdx] is set.
- Set and clear of the same index on one edge: set wins, because the newer producer is outstanding. Different indices update independently.
- Reads are combinational. If wr is active and I_DestRegIdx == I_RdIdxN, O_RdDataN = write value (same-cycle bypass); else O_RdDataN = register[I_RdIdxN]. R0 is an ordinary register.
- Latency: a written value is visible through bypass in the retire cycle and from the register array from the next cycle. Busy-clear and CC take effect on the same edge as the write.
- Bubbles (either stall flag high) are not retired: no count, no write, no busy-clear.

Test Plan:
- Reset, then I_LOCK = 1 with no valid traffic -> all reads 0, O_Busy = 0, O_CC = 3'b010, O_RetireCount = 0.
- Retire ADD-class with I_ALUOut = 16'h8001, dest 3 -> reg3 = 16'h8001, O_CC = 3'b100, O_WrEn = 1 / O_WrIdx = 3 for one cycle, count = 1. Read of index 3 in the same cycle returns 16'h8001 via bypass.
- Retire OP_LDW with I_MemOut = 0, I_ALUOut = 16'h1234, dest 5 -> reg5 = 0, O_CC = 3'b010. Then OP_STW and OP_BRZ -> count +2, registers and CC unchanged, O_WrEn = 0.
- Issue to dest 7 -> O_Busy[7] = 1. Retire a write to 7 with a concurrent issue to 7 -> O_Busy[7] stays 1. Next edge, a write to 7 with no issue -> O_Busy[7] = 0.
- Stall flags high, or I_LOCK = 0, with a valid-looking write to reg 2 -> reg2, count and CC unchanged. Preload count to all-ones and retire once -> count = 0.
- Assert I_RESET on the same edge as a retire to reg 4 and an issue to reg 4 -> reg4 = 0, O_Busy = 0, count = 0.
